input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//   Cleans an asynchronous, bouncing 1-bit input (push-button or switch)
//   before it reaches the registered d input of the downstream flip-flop stage.
//   - Synchronizes the input into the clk domain.
//   - Filters bounces with a stability counter and a 4-state FSM.
//   - Outputs a clean level plus one-cycle rise/fall strobes.
// PARAMETERS
//   SYNC_STAGES   2      flip-flops in the input synchronizer chain (>=2)
//   STABLE_CYCLES 50000  consecutive cycles a new level must persist (>=1)
//   CNT_WIDTH     16     stability counter width; 2**CNT_WIDTH > STABLE_CYCLES
// PORTS
//   clk    input   1  rising-edge clock
//   rst    input   1  asynchronous, active-high reset
//   d_raw  input   1  raw asynchronous input (may bounce)
//   q      output  1  debounced level, registered
//   rise   output  1  one-cycle strobe, asserted with the clock edge where q goes 0->1
//   fall   output  1  one-cycle strobe, asserted with the clock edge where q goes 1->0
// BEHAVIOUR
//   Reset (async assert, released synchronously by design of use):
//     - sync chain = 0, cnt = 0, state = IDLE_LOW
//     - q = 0, rise = 0, fall = 0
//   Synchronizer:
//     - sync[0] <= d_raw; sync[i] <= sync[i-1]
//     - s = sync[SYNC_STAGES-1]; s is the only signal the FSM reads
//   FSM (all transitions on the rising edge of clk):
//     IDLE_LOW:  s==1 -> WAIT_HIGH, cnt<=0; else stay
//     WAIT_HIGH: s==0 -> IDLE_LOW, cnt<=0 (glitch rejected)
//                s==1 && cnt==STABLE_CYCLES-1 -> IDLE_HIGH, q<=1, rise<=1, cnt<=0
//                s==1 otherwise -> cnt<=cnt+1
//     IDLE_HIGH: s==0 -> WAIT_LOW, cnt<=0; else stay
//     WAIT_LOW:  mirror of WAIT_HIGH; completes to IDLE_LOW with q<=0, fall<=1
//   Strobes:
//     - rise/fall default to 0 every cycle; high for exactly one cycle
//     - rise and fall are never high together
//   Latency:
//     - Let E0 be the first edge that samples a new d_raw level.
//     - q changes at edge E0 + SYNC_STAGES + STABLE_CYCLES.
//     - Requires d_raw held at the new level at edges E0..E0+STABLE_CYCLES.
//   Glitch rule: a level held for STABLE_CYCLES or fewer sampling edges never
//     changes q.
//   Counter: never exceeds STABLE_CYCLES-1; no wrap-around is possible.
//   Reset mid-count: any WAIT state aborts; q=0 immediately, independent of clk.
//   Back-to-back: after completion the FSM is IDLE_x. The opposite transition
//     restarts the full latency; there is no shortcut.
// TESTING  (clk period 100 ns, SYNC_STAGES=2, STABLE_CYCLES=4)
//   1 rst=1, d_raw=1 for 3 cycles -> q=0, rise=0, fall=0 throughout reset
//   2 release rst, d_raw 0->1 held; E0 = first sampling edge
//       -> q=1 and rise=1 at edge E0+6; rise=0 at E0+7
//   3 from q=1, d_raw=0 for exactly 4 edges, then back to 1
//       -> q stays 1; fall never asserts
//   4 from q=1, d_raw bounces 0,1,0,1 each cycle, then 0 held
//       -> single fall pulse 6 edges after the held 0 is first sampled; q=0
//   5 d_raw high; assert rst asynchronously mid-WAIT_HIGH (cnt=2)
//       -> q=0 without waiting for a clock edge; after release, full 6-edge
//          latency again
//   6 long random bounce stream
//       -> check q against a behavioural model; rise/fall never coincide and
//          each is exactly 1 cycle

Source files
------------

// File: rtl/input_debouncer.sv
// Debounces an asynchronous 1-bit input: synchronizer chain, stability counter
// and a 4-state FSM producing a clean registered level plus rise/fall strobes.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic q,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   r_q;
    logic                   w_q_nxt;
    logic                   r_rise;
    logic                   w_rise_nxt;
    logic                   r_fall;
    logic                   w_fall_nxt;
    logic                   w_s;

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_raw};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // A WAIT state completes only after STABLE_CYCLES further matching samples.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_q_nxt     = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_q_nxt     = 1'b0;
                    w_fall_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed latency/glitch/reset cases
// plus a random bounce stream compared against a run-length reference model.
module tb_input_debouncer;

    localparam int  SYNC   = 2;
    localparam int  STABLE = 4;
    localparam int  CW     = 3;
    localparam time PERIOD = 100;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic d_raw = 1'b0;
    logic q;
    logic rise;
    logic fall;

    int total = 0;
    int bad   = 0;

    // Reference model: q flips once the synchronized level has differed from q
    // for STABLE+1 consecutive sampling edges.
    bit m_q;
    bit m_rise;
    bit m_fall;
    int run;
    bit hist[$];

    always #(PERIOD / 2) clk = ~clk;

    input_debouncer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d_raw(d_raw),
        .q    (q),
        .rise (rise),
        .fall (fall)
    );

    task automatic model_reset();
        m_q    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        run    = 0;
        hist.delete();
    endtask

    task automatic model_edge(input bit d);
        bit s;
        hist.push_back(d);
        s = (hist.size() > SYNC) ? hist[hist.size() - 1 - SYNC] : 1'b0;
        if (hist.size() > SYNC + 1) void'(hist.pop_front());
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_q) begin
            run++;
            if (run == STABLE + 1) begin
                m_q = s;
                run = 0;
                if (s) m_rise = 1'b1;
                else   m_fall = 1'b1;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic tick(input logic d);
        @(negedge clk);
        d_raw = d;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_edge(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            total++; if (q !== 1'b0)    begin bad++; $display("FAIL reset_q: got %b expected 0", q); end
            total++; if (rise !== 1'b0) begin bad++; $display("FAIL reset_rise: got %b expected 0", rise); end
            total++; if (fall !== 1'b0) begin bad++; $display("FAIL reset_fall: got %b expected 0", fall); end
        end
    endtask

    task automatic test_rise_latency();
        rst = 1'b0;
        repeat (3) tick(1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1);
            total++; if (q !== (k >= 6)) begin bad++; $display("FAIL rise_lat_q k=%0d: got %b expected %b", k, q, (k >= 6)); end
            total++; if (rise !== (k == 6)) begin bad++; $display("FAIL rise_lat_rise k=%0d: got %b expected %b", k, rise, (k == 6)); end
            total++; if (fall !== 1'b0) begin bad++; $display("FAIL rise_lat_fall k=%0d: got %b expected 0", k, fall); end
        end
    endtask

    task automatic test_glitch_reject();
        for (int k = 0; k < 14; k++) begin
            tick((k < STABLE) ? 1'b0 : 1'b1);
            total++; if (q !== 1'b1)    begin bad++; $display("FAIL glitch_q k=%0d: got %b expected 1", k, q); end
            total++; if (fall !== 1'b0) begin bad++; $display("FAIL glitch_fall k=%0d: got %b expected 0", k, fall); end
        end
    endtask

    task automatic test_bounce_fall();
        logic [3:0] pat;
        pat = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick(pat[k]);
            total++; if (q !== 1'b1)    begin bad++; $display("FAIL bounce_q k=%0d: got %b expected 1", k, q); end
            total++; if (fall !== 1'b0) begin bad++; $display("FAIL bounce_fall k=%0d: got %b expected 0", k, fall); end
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0);
            total++; if (q !== (k < 6)) begin bad++; $display("FAIL bounce_held_q k=%0d: got %b expected %b", k, q, (k < 6)); end
            total++; if (fall !== (k == 6)) begin bad++; $display("FAIL bounce_held_fall k=%0d: got %b expected %b", k, fall, (k == 6)); end
            total++; if (rise !== 1'b0) begin bad++; $display("FAIL bounce_held_rise k=%0d: got %b expected 0", k, rise); end
        end
    endtask

    task automatic test_async_reset();
        repeat (8) tick(1'b1);
        total++; if (q !== 1'b1) begin bad++; $display("FAIL areset_pre_q: got %b expected 1", q); end
        #20;
        rst = 1'b1;
        #1;
        total++; if (q !== 1'b0) begin bad++; $display("FAIL areset_from_high_q: got %b expected 0", q); end
        model_reset();
        tick(1'b1);
        rst = 1'b0;
        repeat (3) tick(1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1);
            total++; if (q !== 1'b0) begin bad++; $display("FAIL areset_wait_q k=%0d: got %b expected 0", k, q); end
        end
        #20;
        rst = 1'b1;
        #1;
        total++; if (q !== 1'b0)    begin bad++; $display("FAIL areset_mid_q: got %b expected 0", q); end
        total++; if (rise !== 1'b0) begin bad++; $display("FAIL areset_mid_rise: got %b expected 0", rise); end
        model_reset();
        tick(1'b1);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b1);
            total++; if (q !== (k >= 6)) begin bad++; $display("FAIL areset_relat_q k=%0d: got %b expected %b", k, q, (k >= 6)); end
            total++; if (rise !== (k == 6)) begin bad++; $display("FAIL areset_relat_rise k=%0d: got %b expected %b", k, rise, (k == 6)); end
        end
    endtask

    task automatic test_random();
        logic lvl;
        logic prev_rise;
        logic prev_fall;
        int   len;
        lvl       = d_raw;
        prev_rise = rise;
        prev_fall = fall;
        for (int seg = 0; seg < 60; seg++) begin
            lvl = ~lvl;
            len = int'($urandom_range(1, 2 * STABLE + 1));
            for (int i = 0; i < len; i++) begin
                tick(lvl);
                total++; if (q !== m_q)       begin bad++; $display("FAIL rand_q seg=%0d: got %b expected %b", seg, q, m_q); end
                total++; if (rise !== m_rise) begin bad++; $display("FAIL rand_rise seg=%0d: got %b expected %b", seg, rise, m_rise); end
                total++; if (fall !== m_fall) begin bad++; $display("FAIL rand_fall seg=%0d: got %b expected %b", seg, fall, m_fall); end
                total++; if ((rise & fall) !== 1'b0) begin bad++; $display("FAIL rand_coincide seg=%0d: got rise=%b fall=%b expected not both", seg, rise, fall); end
                total++; if (((prev_rise & rise) | (prev_fall & fall)) !== 1'b0) begin
                    bad++; $display("FAIL rand_strobe_width seg=%0d: got strobe high two cycles expected one", seg);
                end
                prev_rise = rise;
                prev_fall = fall;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rise_latency();
        repeat (3) tick(1'b1);
        test_glitch_reject();
        test_bounce_fall();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
